// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect arbiter: turns stage wait sources and MM-stage
// exceptions into per-stage enables, bubble strobes, a PC redirect and a stall counter.
module pipe_ctrl #(
  parameter int unsigned EXC_VEC_W = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_hazard,
  input  logic                 stall_muldiv,
  input  logic                 ireq_wait,
  input  logic                 dreq_wait,
  input  logic                 except,
  input  logic [EXC_VEC_W-1:0] except_pc,
  output logic                 en_if,
  output logic                 en_id,
  output logic                 en_ex,
  output logic                 en_mm,
  output logic                 en_wb,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_mm,
  output logic                 flush_wb,
  output logic                 redirect_valid,
  output logic [EXC_VEC_W-1:0] redirect_pc,
  output logic                 discard_fetch,
  output logic [CNT_W-1:0]     stall_cycles
);

  // DRAIN: the PC already points at the new target but an old fetch is still in flight
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign stall_cycles = cnt_q;

  always_comb begin
    en_if          = 1'b1;
    en_id          = 1'b1;
    en_ex          = 1'b1;
    en_mm          = 1'b1;
    en_wb          = 1'b1;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_mm       = 1'b0;
    flush_wb       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    discard_fetch  = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;

    if (rst) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
      flush_mm = 1'b1;
      flush_wb = 1'b1;
      state_d  = RUN;
    end else if (except) begin
      // Exception overrides every stall; a fetch still outstanding becomes stale
      flush_id       = 1'b1;
      flush_ex       = 1'b1;
      flush_mm       = 1'b1;
      flush_wb       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = except_pc;
      discard_fetch  = (state_q == DRAIN);
      state_d        = ireq_wait ? DRAIN : RUN;
    end else begin
      if (dreq_wait) begin
        en_if    = 1'b0;
        en_id    = 1'b0;
        en_ex    = 1'b0;
        en_mm    = 1'b0;
        flush_wb = 1'b1;
      end else if (stall_muldiv) begin
        en_if    = 1'b0;
        en_id    = 1'b0;
        en_ex    = 1'b0;
        flush_mm = 1'b1;
      end else if (stall_hazard) begin
        en_if    = 1'b0;
        en_id    = 1'b0;
        flush_ex = 1'b1;
      end else if (ireq_wait) begin
        en_if    = 1'b0;
        flush_id = 1'b1;
      end

      // While draining, IF/ID are owned by the drain; EX..WB keep the stall result
      if (state_q == DRAIN) begin
        discard_fetch = 1'b1;
        en_if         = 1'b0;
        en_id         = 1'b1;
        flush_id      = 1'b1;
        if (!ireq_wait) begin
          state_d = RUN;
        end
      end
    end

    if (!rst && !en_if && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; the counter is narrowed so that
// saturation is reachable in a few hundred cycles.
module tb_pipe_ctrl;

  localparam int unsigned EXC_VEC_W = 32;
  localparam int unsigned CNT_W     = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall_hazard, stall_muldiv, ireq_wait, dreq_wait, except;
  logic [EXC_VEC_W-1:0] except_pc;
  logic                 en_if, en_id, en_ex, en_mm, en_wb;
  logic                 flush_id, flush_ex, flush_mm, flush_wb;
  logic                 redirect_valid, discard_fetch;
  logic [EXC_VEC_W-1:0] redirect_pc;
  logic [CNT_W-1:0]     stall_cycles;
  logic [4:0]           en_v;
  logic [3:0]           fl_v;

  int pass_cnt = 0;
  int total    = 0;

  assign en_v = {en_if, en_id, en_ex, en_mm, en_wb};
  assign fl_v = {flush_id, flush_ex, flush_mm, flush_wb};

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VEC_W(EXC_VEC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stall_hazard(stall_hazard), .stall_muldiv(stall_muldiv),
    .ireq_wait(ireq_wait), .dreq_wait(dreq_wait),
    .except(except), .except_pc(except_pc),
    .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mm(en_mm), .en_wb(en_wb),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mm(flush_mm), .flush_wb(flush_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .discard_fetch(discard_fetch), .stall_cycles(stall_cycles)
  );

  task automatic drive(input logic h, input logic m, input logic iw, input logic dw,
                       input logic ex, input logic [EXC_VEC_W-1:0] pc);
    stall_hazard = h;
    stall_muldiv = m;
    ireq_wait    = iw;
    dreq_wait    = dw;
    except       = ex;
    except_pc    = pc;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (en_v !== 5'b11111 || fl_v !== 4'b1111 || redirect_valid !== 1'b0 ||
          discard_fetch !== 1'b0 || redirect_pc !== '0)
        $display("FAIL reset_outputs: en=%b fl=%b rv=%b disc=%b pc=%h, want 11111 1111 0 0 0",
                 en_v, fl_v, redirect_valid, discard_fetch, redirect_pc);
      else pass_cnt++;
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (en_v !== 5'b11111 || fl_v !== 4'b0000 || redirect_valid !== 1'b0 || stall_cycles !== 8'd0)
      $display("FAIL post_reset: en=%b fl=%b rv=%b cnt=%0d, want 11111 0000 0 0",
               en_v, fl_v, redirect_valid, stall_cycles);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_hazard();
    drive(1, 0, 0, 0, 0, '0);
    repeat (2) begin
      @(negedge clk);
      total++;
      if (en_v !== 5'b00111 || fl_v !== 4'b0100 || redirect_valid !== 1'b0)
        $display("FAIL hazard: en=%b fl=%b rv=%b, want 00111 0100 0", en_v, fl_v, redirect_valid);
      else pass_cnt++;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'd2)
      $display("FAIL hazard_count: cnt=%0d, want 2", stall_cycles);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_priority();
    drive(1, 1, 0, 1, 0, '0);
    @(negedge clk);
    total++;
    if (en_v !== 5'b00001 || fl_v !== 4'b0001)
      $display("FAIL prio_dreq: en=%b fl=%b, want 00001 0001", en_v, fl_v);
    else pass_cnt++;
    next_cycle();
    drive(1, 1, 0, 0, 0, '0);
    @(negedge clk);
    total++;
    if (en_v !== 5'b00011 || fl_v !== 4'b0010)
      $display("FAIL prio_muldiv: en=%b fl=%b, want 00011 0010", en_v, fl_v);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_ifetch();
    drive(0, 0, 1, 0, 0, '0);
    @(negedge clk);
    total++;
    if (en_v !== 5'b01111 || fl_v !== 4'b1000 || discard_fetch !== 1'b0)
      $display("FAIL ifetch_wait: en=%b fl=%b disc=%b, want 01111 1000 0", en_v, fl_v, discard_fetch);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_except();
    drive(1, 1, 0, 1, 1, 32'hBFC0_0380);
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0380 ||
        en_v !== 5'b11111 || fl_v !== 4'b1111 || discard_fetch !== 1'b0)
      $display("FAIL except: rv=%b pc=%h en=%b fl=%b disc=%b, want 1 bfc00380 11111 1111 0",
               redirect_valid, redirect_pc, en_v, fl_v, discard_fetch);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b0 || en_v !== 5'b11111 || stall_cycles !== 8'd5)
      $display("FAIL except_after: disc=%b en=%b cnt=%0d, want 0 11111 5",
               discard_fetch, en_v, stall_cycles);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_drain();
    drive(0, 0, 1, 0, 1, 32'h8000_0180);
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || discard_fetch !== 1'b0)
      $display("FAIL drain_entry: rv=%b pc=%h disc=%b, want 1 80000180 0",
               redirect_valid, redirect_pc, discard_fetch);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 1, 0, 0, '0);
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b1 || en_v !== 5'b01111 || fl_v !== 4'b1000 || redirect_valid !== 1'b0)
      $display("FAIL drain_1: disc=%b en=%b fl=%b rv=%b, want 1 01111 1000 0",
               discard_fetch, en_v, fl_v, redirect_valid);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 1, 0, 1, 32'hBFC0_0200);
    @(negedge clk);
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0200 || discard_fetch !== 1'b1 ||
        fl_v !== 4'b1111)
      $display("FAIL drain_except: rv=%b pc=%h disc=%b fl=%b, want 1 bfc00200 1 1111",
               redirect_valid, redirect_pc, discard_fetch, fl_v);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 1, 0, 0, '0);
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b1 || en_v !== 5'b01111)
      $display("FAIL drain_stay: disc=%b en=%b, want 1 01111", discard_fetch, en_v);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 0, 0, 0, '0);
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b1 || en_v !== 5'b01111 || fl_v !== 4'b1000)
      $display("FAIL drain_last: disc=%b en=%b fl=%b, want 1 01111 1000", discard_fetch, en_v, fl_v);
    else pass_cnt++;
    next_cycle();
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b0 || en_v !== 5'b11111 || fl_v !== 4'b0000 || stall_cycles !== 8'd8)
      $display("FAIL drain_exit: disc=%b en=%b fl=%b cnt=%0d, want 0 11111 0000 8",
               discard_fetch, en_v, fl_v, stall_cycles);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_saturate_and_reset();
    drive(1, 0, 0, 0, 0, '0);
    repeat (246) next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'hFE)
      $display("FAIL sat_pre: cnt=%h, want fe", stall_cycles);
    else pass_cnt++;
    repeat (4) next_cycle();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'hFF)
      $display("FAIL sat_hold: cnt=%h, want ff", stall_cycles);
    else pass_cnt++;
    drive(0, 0, 1, 0, 1, 32'h8000_0000);
    next_cycle();
    drive(0, 0, 1, 0, 0, '0);
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b1 || stall_cycles !== 8'hFF)
      $display("FAIL sat_drain: disc=%b cnt=%h, want 1 ff", discard_fetch, stall_cycles);
    else pass_cnt++;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b0 || en_v !== 5'b11111 || fl_v !== 4'b1111 || redirect_valid !== 1'b0)
      $display("FAIL rst_in_drain: disc=%b en=%b fl=%b rv=%b, want 0 11111 1111 0",
               discard_fetch, en_v, fl_v, redirect_valid);
    else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (discard_fetch !== 1'b0 || stall_cycles !== 8'd0 || en_v !== 5'b01111 || fl_v !== 4'b1000)
      $display("FAIL rst_after_drain: disc=%b cnt=%0d en=%b fl=%b, want 0 0 01111 1000",
               discard_fetch, stall_cycles, en_v, fl_v);
    else pass_cnt++;
    next_cycle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, '0);
    next_cycle();
    test_reset();
    test_hazard();
    test_priority();
    test_ifetch();
    test_except();
    test_drain();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
